// File: rtl/scan_sel_gen_pkg.sv
// rtl/scan_sel_gen_pkg.sv - shared widths, line count and default dwell for the scan select generator
package scan_sel_gen_pkg;

    localparam int IDX_W         = 3;
    localparam int N_LINES       = 8;
    localparam int DWELL_DEFAULT = 4;

    typedef logic [IDX_W-1:0]   idx_t;
    typedef logic [N_LINES-1:0] line_mask_t;

endpackage

// File: rtl/scan_sel_gen_if.sv
// rtl/scan_sel_gen_if.sv - control and select bundle between a scan controller and the select generator
interface scan_sel_gen_if;
    import scan_sel_gen_pkg::*;

    logic       en;
    line_mask_t mask;
    logic       load;
    idx_t       load_val;
    idx_t       sel;
    logic       sel_valid;
    logic       wrap;

    modport master (
        output en, mask, load, load_val,
        input  sel, sel_valid, wrap
    );

    modport slave (
        input  en, mask, load, load_val,
        output sel, sel_valid, wrap
    );

endinterface

// File: rtl/scan_sel_gen_next_idx8.sv
// rtl/scan_sel_gen_next_idx8.sv - circular search for the next eligible line after cur
module next_idx8
    import scan_sel_gen_pkg::*;
(
    input  idx_t       cur,
    input  line_mask_t mask,
    output idx_t       nxt,
    output logic       found,
    output logic       wrapped
);

    idx_t cand;

    // Scan offsets 8 down to 1 so the nearest eligible line wins; offset 8 is cur itself.
    always_comb begin
        nxt   = cur;
        found = 1'b0;
        cand  = cur;
        for (int k = N_LINES; k >= 1; k--) begin
            cand = cur + idx_t'(k);
            if (mask[cand]) begin
                nxt   = cand;
                found = 1'b1;
            end
        end
        wrapped = found && (nxt <= cur);
    end

endmodule

// File: rtl/scan_sel_gen.sv
// rtl/scan_sel_gen.sv - dwell-timed circular select index generator for a 3-to-8 line decoder
module scan_sel_gen
    import scan_sel_gen_pkg::*;
#(
    parameter int DWELL = DWELL_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    scan_sel_gen_if.slave bus
);

    localparam logic [7:0] DCNT_LAST = 8'(DWELL - 1);

    idx_t       sel_q;
    logic       sel_valid_q;
    logic       wrap_q;
    logic [7:0] dcnt;

    idx_t nxt;
    logic found;
    logic wrapped;

    next_idx8 u_next_idx8 (
        .cur     (sel_q),
        .mask    (bus.mask),
        .nxt     (nxt),
        .found   (found),
        .wrapped (wrapped)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q       <= '0;
            dcnt        <= '0;
            sel_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
        end else if (bus.load) begin
            sel_q       <= bus.load_val;
            dcnt        <= '0;
            wrap_q      <= 1'b0;
            sel_valid_q <= bus.en & bus.mask[bus.load_val];
        end else if (!bus.en) begin
            sel_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
        end else if (!found) begin
            dcnt        <= '0;
            sel_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
        end else if (!bus.mask[sel_q] || dcnt == DCNT_LAST) begin
            // An ineligible current line is skipped immediately instead of dwelling on it.
            sel_q       <= nxt;
            dcnt        <= '0;
            wrap_q      <= wrapped;
            sel_valid_q <= 1'b1;
        end else begin
            dcnt        <= dcnt + 8'd1;
            wrap_q      <= 1'b0;
            sel_valid_q <= 1'b1;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.sel_valid = sel_valid_q;
    assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_scan_sel_gen.sv
// tb/tb_scan_sel_gen.sv - four dwell variants driven in lockstep and checked against a behavioural model
module tb_scan_sel_gen;

    localparam int NDUT = 4;
    localparam int DWC [NDUT] = '{4, 2, 3, 1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [7:0] mask = 8'h00;
    logic [2:0] load_val = 3'd0;

    logic [2:0] o_sel   [NDUT];
    logic       o_valid [NDUT];
    logic       o_wrap  [NDUT];

    int m_sel   [NDUT];
    int m_cnt   [NDUT];
    int m_valid [NDUT];
    int m_wrap  [NDUT];

    int n_vec = 0;
    int n_err = 0;
    int wrap_seen = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        scan_sel_gen_if bus ();
        assign bus.en       = en;
        assign bus.mask     = mask;
        assign bus.load     = load;
        assign bus.load_val = load_val;

        scan_sel_gen #(.DWELL(DWC[g])) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );

        assign o_sel[g]   = bus.sel;
        assign o_valid[g] = bus.sel_valid;
        assign o_wrap[g]  = bus.wrap;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NDUT; i++) begin
            m_sel[i]   = 0;
            m_cnt[i]   = 0;
            m_valid[i] = 0;
            m_wrap[i]  = 0;
        end
    endtask

    // Rules applied at one rising edge, in priority order: load, enable, empty mask, advance, dwell.
    task automatic model_edge();
        for (int i = 0; i < NDUT; i++) begin
            if (load) begin
                m_sel[i]   = int'(load_val);
                m_cnt[i]   = 0;
                m_wrap[i]  = 0;
                m_valid[i] = (en && mask[load_val]) ? 1 : 0;
            end else if (!en) begin
                m_valid[i] = 0;
                m_wrap[i]  = 0;
            end else if (mask == 8'h00) begin
                m_cnt[i]   = 0;
                m_valid[i] = 0;
                m_wrap[i]  = 0;
            end else if (!mask[m_sel[i]] || m_cnt[i] == DWC[i] - 1) begin
                int nx;
                nx = -1;
                for (int k = 1; k <= 8 && nx < 0; k++)
                    if (mask[(m_sel[i] + k) % 8]) nx = (m_sel[i] + k) % 8;
                m_wrap[i]  = (nx <= m_sel[i]) ? 1 : 0;
                m_sel[i]   = nx;
                m_cnt[i]   = 0;
                m_valid[i] = 1;
            end else begin
                m_cnt[i]   = m_cnt[i] + 1;
                m_wrap[i]  = 0;
                m_valid[i] = 1;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("%s.d%0d.sel", tag, i), int'(o_sel[i]), m_sel[i]);
            check($sformatf("%s.d%0d.valid", tag, i), int'(o_valid[i]), m_valid[i]);
            check($sformatf("%s.d%0d.wrap", tag, i), int'(o_wrap[i]), m_wrap[i]);
        end
    endtask

    task automatic step(input string tag, input int n);
        repeat (n) begin
            @(posedge clk);
            if (rst) model_reset();
            else     model_edge();
            #1;
            compare_all(tag);
            if (o_wrap[0]) wrap_seen++;
        end
    endtask

    // Called at posedge+1; asserts reset between edges and releases it just after the next edge.
    task automatic pulse_rst();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        compare_all("async_rst");
        @(posedge clk);
        model_reset();
        #1;
        compare_all("rst_hold");
        rst = 1'b0;
    endtask

    initial begin
        step("reset", 3);
        rst  = 1'b0;

        mask = 8'hFF;
        en   = 1'b1;
        wrap_seen = 0;
        step("sweep", 34);
        check("sweep_wrap_count", wrap_seen, 1);

        pulse_rst();
        mask = 8'b1000_0101;
        step("sparse", 16);

        pulse_rst();
        mask = 8'hFF;
        step("pre_load", 2);
        load     = 1'b1;
        load_val = 3'd5;
        step("load", 1);
        check("load_sel", int'(o_sel[0]), 5);
        load = 1'b0;
        step("post_load", 6);

        mask = 8'hFF;
        step("pre_clear", 2);
        mask = 8'h00;
        step("mask_clear", 5);
        mask = 8'h10;
        step("mask_restore", 1);
        check("restore_sel", int'(o_sel[0]), 4);
        step("mask_restore", 3);

        mask     = 8'hFF;
        load     = 1'b1;
        load_val = 3'd3;
        step("load3", 1);
        load = 1'b0;
        en   = 1'b0;
        step("en_low", 10);
        check("en_low_sel", int'(o_sel[0]), 3);
        pulse_rst();

        en   = 1'b1;
        mask = 8'h08;
        step("single", 12);

        repeat (600) begin
            en = ($urandom_range(0, 9) != 0);
            case ($urandom_range(0, 9))
                0:       mask = 8'h00;
                1, 2:    mask = 8'h01 << $urandom_range(0, 7);
                3:       mask = 8'hFF;
                default: mask = 8'($urandom);
            endcase
            load     = ($urandom_range(0, 19) == 0);
            load_val = 3'($urandom);
            if ($urandom_range(0, 149) == 0) begin
                load = 1'b0;
                pulse_rst();
            end
            step("rand", 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/scan_sel_gen.md
SCAN_SEL_GEN -- requirements
Module: scan_sel_gen

Interface
REQ-001 SHALL have parameter DWELL, default 4, giving the number of enabled clk cycles each select index is held; legal range 1..255.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port en  input  1  advance enable; when low, all internal state freezes.
REQ-005 SHALL have port mask  input  8  per-line enable; bit i=1 makes index i eligible for selection.
REQ-006 SHALL have port load  input  1  synchronous load strobe.
REQ-007 SHALL have port load_val  input  3  index forced onto sel when load=1.
REQ-008 SHALL have port sel  output  3  registered select index; drives the a input of the 3-to-8 decoder.
REQ-009 SHALL have port sel_valid  output  1  registered; 1 when the current sel is eligible and en is high.
REQ-010 SHALL have port wrap  output  1  registered one-cycle pulse when an advance crosses from a higher index to a lower-or-equal index.

Function
REQ-011 SHALL keep an 8-bit dwell counter dcnt that counts 0..DWELL-1 on each cycle with en=1.
REQ-012 SHALL advance sel when en=1 and dcnt=DWELL-1, then clear dcnt to 0 in the same cycle.
REQ-013 SHALL advance sel to the next index, circularly ascending from sel+1 (7 wraps to 0), whose mask bit is 1.
REQ-014 SHALL, when only mask[sel] is set, keep sel unchanged on advance, clear dcnt, and pulse wrap.
REQ-015 SHALL, when mask=8'h00 and en=1, hold sel, hold dcnt at 0, and drive sel_valid=0 and wrap=0.
REQ-016 SHALL, when en=1 and mask[sel]=0 while mask is nonzero, advance on the next edge regardless of dcnt and clear dcnt (no dwell on an ineligible line).
REQ-017 SHALL, when load=1, set sel=load_val and clear dcnt, with priority over en, advance and mask; wrap=0 that cycle.
REQ-018 SHALL update sel_valid each cycle to en AND mask[new sel], where new sel is the value sel takes at that edge.
REQ-019 SHALL assert wrap for exactly the cycle following an advance edge whose new index is less than or equal to the old index; otherwise wrap=0.
REQ-020 SHALL, with en=0, hold sel, dcnt and wrap=0, and drive sel_valid=0.
REQ-021 SHALL, with DWELL=1, advance on every enabled cycle.
REQ-022 SHALL take effect for a mask change on the first edge after the change; there is no mask pipeline.

Reset
REQ-023 SHALL, while rst=1, asynchronously force sel=3'b000, dcnt=0, sel_valid=0 and wrap=0.
REQ-024 SHALL, after rst deasserts mid-sequence, restart counting from index 0 with a full DWELL-cycle hold, provided mask[0]=1.
REQ-025 SHALL treat rst as dominant over load and en.

Structure
REQ-026 SHALL place in a shared package: the index width constant (3), the line count constant (8), and the default DWELL value.
REQ-027 SHALL implement the circular next-eligible-index search as one combinational sub-module, next_idx8, with these ports:
- inputs: cur[2:0], mask[7:0];
- outputs: nxt[2:0], found, wrapped.
REQ-028 SHALL keep all output registers in scan_sel_gen; next_idx8 SHALL hold no state.

Verification
REQ-029 SHALL cover the basic sweep: DWELL=4, mask=8'hFF, en=1 from reset.
- sel steps 0,1,...,7,0 with each value held 4 cycles;
- wrap pulses once at the 7->0 transition;
- sel_valid stays 1.
REQ-030 SHALL cover a sparse mask: mask=8'b1000_0101, DWELL=2.
- sel sequence is 0,2,7,0;
- wrap pulses on 7->0 only.
REQ-031 SHALL cover load during a hold: load=1 with load_val=5 at dcnt=2.
- sel=5 and dcnt=0 on the next edge;
- sel_valid = mask[5];
- sel then advances after 4 further cycles.
REQ-032 SHALL cover mask cleared: mask goes to 8'h00 mid-hold.
- sel frozen, sel_valid=0, no wrap;
- after mask restores to 8'h10, sel moves to 4 on the next edge.
REQ-033 SHALL cover en gating and reset: en=0 for 10 cycles at sel=3, then rst pulsed asynchronously between edges.
- during en=0: sel stays 3, sel_valid=0;
- on rst: sel=0, sel_valid=0 and wrap=0 immediately, without waiting for a clk edge.
REQ-034 SHALL cover single-line wrap: mask=8'h08, DWELL=3.
- sel stays 3;
- wrap pulses every 3 cycles;
- sel_valid=1.
